fake_n64_controller_tx: RTL
===========================

Name: fake_n64_controller_tx

Overview:
Transmit half of the fake N64 controller. It waits for the command-complete toggle from the controller receiver and then drives the controller's reply onto the N64 one-wire data line. For INFO and RESET it sends the 3-byte identity. For BUTTON STATUS it sends the 4-byte button word. Every reply ends with a controller stop bit. While it transmits, the block asserts cur_operation so the receiver ignores the line.

Parameters:
CLKS_PER_US, 50, clk cycles per microsecond; all line timing is derived from this.
TURNAROUND_US, 2, idle-high gap in µs between detecting the handoff and driving the first bit.
INFO_BYTE2, 8'h02, third info byte (8'h02 = no pak, 8'h01 = pak present).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
tx_handoff  input  1  toggle from the receiver, asynchronous to clk; each edge (either direction) requests one reply.
cmd  input  8  command byte from the receiver; stable when tx_handoff toggles.
button_state  input  32  live button/stick word, transmitted MSB first.
data_tx_low  output  1  1 = pull the data line low; 0 = release it (external pull-up makes it high).
cur_operation  output  1  1 = transmit in progress; feeds the receiver.
tx_done  output  1  one-cycle pulse after the stop bit is released.

Behaviour:
- Reset (async assert, sync release): data_tx_low=0, cur_operation=0, tx_done=0, state=IDLE, all counters 0. The synchronizer and the last-seen handoff register both load 0.
- Handoff detection:
  - tx_handoff passes through a 2-FF synchronizer, then is compared with the registered last value; a mismatch is a request.
  - Detection occurs 3 clk after the toggle.
  - The last-seen register updates every cycle, including while busy, so toggles that arrive while busy are dropped, not queued.
- On a request in IDLE:
  - Latch cmd and button_state into shadow registers.
  - Latched cmd 8'h00 or 8'hFF: payload = {8'h05, 8'h00, INFO_BYTE2}, length 24.
  - Latched cmd 8'h01: payload = button_state, length 32.
  - Any other cmd: no reply; stay IDLE, cur_operation stays 0, no tx_done.
  - Valid cmd: go to TURNAROUND and set cur_operation=1 on the same edge.
- States:
  - IDLE.
  - TURNAROUND: line released for TURNAROUND_US*CLKS_PER_US cycles.
  - BIT_LOW: line low for 1 µs if the bit is 1, 3 µs if it is 0.
  - BIT_HIGH: line released for the rest of the 4 µs bit cell.
  - STOP: line low for 2 µs.
  - Return to IDLE after the stop bit.
- Bit order and cell timing:
  - Bits are sent MSB first: payload bit (length-1) down to bit 0.
  - Every bit cell is exactly 4*CLKS_PER_US cycles with no gaps between cells.
  - data_tx_low is registered and changes exactly on phase boundaries.
- End of reply:
  - After the last BIT_HIGH, go to STOP.
  - When STOP ends: release the line, clear cur_operation, pulse tx_done for 1 clk, return to IDLE.
- Counters:
  - The µs-phase counter is wide enough for 4*CLKS_PER_US-1 and reloads on every phase change.
  - The bit counter is 6-bit, loads with length-1 and decrements; the 0→underflow case selects STOP and never wraps into a resend.
- Reset mid-reply: the line is released immediately (asynchronously), cur_operation=0, and the reply is abandoned with no tx_done.
- button_state changing mid-reply has no effect; only the shadow copy is sent.
- A request arriving in the same cycle as tx_done/IDLE entry is ignored unless it is detected in IDLE on a later cycle.

Test Plan:
(bench uses CLKS_PER_US=4, TURNAROUND_US=2)
- cmd=8'h00, toggle tx_handoff → cur_operation rises 3 clk later; 8 clk released; line carries 05 00 02 MSB first. Bit 0 = 12 clk low + 4 high; bit 1 = 4 low + 12 high. Then 8 clk low, release, tx_done pulse. Total 400 clk after detection.
- cmd=8'h01, button_state=32'h8001_7F80 → 32 cells decode to 8001_7F80; button_state changed to 0 mid-reply is not sent.
- cmd=8'h02 with toggle → data_tx_low stays 0, cur_operation stays 0, no tx_done for 500 clk.
- Second toggle during a BUTTON STATUS reply → no second reply; exactly one tx_done.
- reset_n low at bit 10 of a reply → data_tx_low=0 and cur_operation=0 without a clk edge. After release, a new toggle with cmd=8'hFF gives a full, correct info reply.
- Back-to-back: toggle 1 clk after tx_done with cmd=8'h01 → second reply starts with a full turnaround and is timed correctly.

Source files
------------

// File: rtl/fake_n64_controller_tx.sv
// Transmit half of the fake N64 controller: on a handoff toggle from the
// receiver it drives the reply to the last command onto the one-wire line.
// INFO/RESET send the 3-byte identity, BUTTON STATUS sends the 32-bit button
// word, and every reply ends with a 2 us controller stop bit.
module fake_n64_controller_tx #(
  parameter int          CLKS_PER_US   = 50,
  parameter int          TURNAROUND_US = 2,
  parameter logic [7:0]  INFO_BYTE2    = 8'h02
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_handoff,
  input  logic [7:0]  cmd,
  input  logic [31:0] button_state,
  output logic        data_tx_low,
  output logic        cur_operation,
  output logic        tx_done
);

  localparam int CELL_CYC = 4 * CLKS_PER_US;
  localparam int TURN_CYC = TURNAROUND_US * CLKS_PER_US;
  localparam int MAX_CYC  = (CELL_CYC > TURN_CYC) ? CELL_CYC : TURN_CYC;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter reload values: each phase lasts (load + 1) cycles.
  localparam cnt_t ONE_US_LOAD   = cnt_t'(CLKS_PER_US - 1);
  localparam cnt_t THREE_US_LOAD = cnt_t'(3 * CLKS_PER_US - 1);
  localparam cnt_t STOP_LOAD     = cnt_t'(2 * CLKS_PER_US - 1);
  localparam cnt_t TURN_LOAD     = cnt_t'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    TURNAROUND,
    BIT_LOW,
    BIT_HIGH,
    STOP
  } state_t;

  // Selects payload bit idx; written as a compare loop so a 6-bit counter
  // can address the 32-bit shadow word without a width mismatch.
  function automatic logic bit_at(input logic [31:0] word, input logic [5:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (idx == 6'(i)) b = word[i];
    end
    return b;
  endfunction

  // A '1' is a short low pulse (1 us), a '0' a long one (3 us).
  function automatic cnt_t low_load(input logic b);
    return b ? ONE_US_LOAD : THREE_US_LOAD;
  endfunction

  function automatic cnt_t high_load(input logic b);
    return b ? THREE_US_LOAD : ONE_US_LOAD;
  endfunction

  logic        sync1_q, sync2_q, last_q;
  logic        request;
  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] payload_q, payload_d;
  logic        line_q, line_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cur_bit, next_bit;

  // Handoff synchronizer plus last-seen copy; the last-seen copy tracks every
  // cycle so toggles arriving mid-reply are dropped rather than queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each stage sample the previous
      // stage's old value, which is what makes this a real 2-FF chain.
      sync1_q <= tx_handoff;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
    end
  end

  assign request  = sync2_q ^ last_q;
  assign cur_bit  = bit_at(payload_q, bit_q);
  assign next_bit = bit_at(payload_q, bit_q - 6'd1);

  // State, counters, shadow payload and registered line outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      payload_q <= '0;
      line_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      payload_q <= payload_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: each phase runs its counter down to zero, then reloads
  // it for the next phase and sets the line level that phase needs.
  always_comb begin
    logic start;
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    start     = 1'b0;
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
    bit_d     = bit_q;
    payload_d = payload_q;
    line_d    = line_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (request) begin
          if (cmd == 8'h00 || cmd == 8'hFF) begin
            payload_d = {8'h00, 8'h05, 8'h00, INFO_BYTE2};
            bit_d     = 6'd23;
            start     = 1'b1;
          end else if (cmd == 8'h01) begin
            payload_d = button_state;
            bit_d     = 6'd31;
            start     = 1'b1;
          end
          if (start) begin
            state_d = TURNAROUND;
            cnt_d   = TURN_LOAD;
            line_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      TURNAROUND: begin
        if (cnt_q == '0) begin
          state_d = BIT_LOW;
          cnt_d   = low_load(cur_bit);
          line_d  = 1'b1;
        end
      end

      BIT_LOW: begin
        if (cnt_q == '0) begin
          state_d = BIT_HIGH;
          cnt_d   = high_load(cur_bit);
          line_d  = 1'b0;
        end
      end

      BIT_HIGH: begin
        if (cnt_q == '0) begin
          line_d = 1'b1;
          if (bit_q == 6'd0) begin
            state_d = STOP;
            cnt_d   = STOP_LOAD;
          end else begin
            state_d = BIT_LOW;
            bit_d   = bit_q - 6'd1;
            cnt_d   = low_load(next_bit);
          end
        end
      end

      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          line_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        line_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign data_tx_low   = line_q;
  assign cur_operation = busy_q;
  assign tx_done       = done_q;

endmodule
